// File: rtl/pe_fixed_pipe_if.sv
// Operand/result bundle for pe_fixed_pipe.
// The master side supplies operands and consumes results; the slave side is the PE.
interface pe_fixed_pipe_if #(
  parameter int WIDTH = 32
);
  logic [7*WIDTH-1:0] probs;
  logic [WIDTH-1:0]   prior;
  logic [WIDTH-1:0]   diag_m;
  logic [WIDTH-1:0]   diag_i;
  logic [WIDTH-1:0]   diag_d;
  logic [WIDTH-1:0]   left_m;
  logic [WIDTH-1:0]   left_d;
  logic               row_start;
  logic               in_valid;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   cur_m;
  logic [WIDTH-1:0]   cur_i;
  logic [WIDTH-1:0]   cur_d;
  logic [WIDTH-1:0]   prev_m;
  logic [WIDTH-1:0]   prev_i;
  logic [WIDTH-1:0]   prev_d;

  modport master (
    output probs, prior, diag_m, diag_i, diag_d, left_m, left_d, row_start,
    output in_valid, out_ready,
    input  in_ready, out_valid,
    input  cur_m, cur_i, cur_d, prev_m, prev_i, prev_d
  );

  modport slave (
    input  probs, prior, diag_m, diag_i, diag_d, left_m, left_d, row_start,
    input  in_valid, out_ready,
    output in_ready, out_valid,
    output cur_m, cur_i, cur_d, prev_m, prev_i, prev_d
  );
endinterface

// File: rtl/pe_fixed_pipe.sv
// Fixed-point pair-HMM style processing element: one shared multiplier walks
// seven transition products (M, I, D accumulators), then scales M by the prior.
// Unsigned fixed point, 1.0 = 2^FRAC; multiply truncates after >> FRAC.
// Optional build macro PE_FIXED_SATURATE_EN: multiplies and adds clamp to
// all-ones instead of wrapping modulo 2^WIDTH.
module pe_fixed_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 30
) (
  input logic            clk,
  input logic            reset_n,
  pe_fixed_pipe_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MAC, FINAL, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       idx_reg;
  logic [WIDTH-1:0] prob_in  [7];
  logic [WIDTH-1:0] prob_reg [7];
  logic [WIDTH-1:0] prior_reg, diag_m_reg, diag_i_reg, diag_d_reg;
  logic [WIDTH-1:0] left_m_reg, left_d_reg, own_m_reg, own_i_reg;
  logic [WIDTH-1:0] acc_m_reg, acc_i_reg, acc_d_reg;
  logic [WIDTH-1:0] result_m_reg, result_i_reg, result_d_reg;
  logic [WIDTH-1:0] cur_m_reg, cur_i_reg, cur_d_reg;
  logic [WIDTH-1:0] prev_m_reg, prev_i_reg, prev_d_reg;
  logic [WIDTH-1:0] mul_a, mul_b, mul_res;
  logic [2*WIDTH-1:0] mul_full;
  logic             in_ready, out_valid;

  localparam logic [2*WIDTH-1:0] MUL_MAX = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};

  // Split the packed probability bus: index order a_mm, a_im, a_dm, a_mi, a_ii, a_md, a_dd.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_unpack
      assign prob_in[gi] = bus.probs[gi*WIDTH +: WIDTH];
    end
  endgenerate

  function automatic logic [WIDTH-1:0] fx_add(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
`ifdef PE_FIXED_SATURATE_EN
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  // Shared multiplier; FINAL reuses it for prior * acc_m.
  assign mul_full = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
`ifdef PE_FIXED_SATURATE_EN
  assign mul_res = ((mul_full >> FRAC) > MUL_MAX) ? {WIDTH{1'b1}} : WIDTH'(mul_full >> FRAC);
`else
  assign mul_res = WIDTH'(mul_full >> FRAC);
`endif

  // Operand select for the shared multiplier by product index (or FINAL scaling).
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state_reg == FINAL) begin
      mul_a = prior_reg;
      mul_b = acc_m_reg;
    end else begin
      case (idx_reg)
        3'd0: begin mul_a = prob_reg[0]; mul_b = diag_m_reg; end
        3'd1: begin mul_a = prob_reg[1]; mul_b = diag_i_reg; end
        3'd2: begin mul_a = prob_reg[2]; mul_b = diag_d_reg; end
        3'd3: begin mul_a = prob_reg[3]; mul_b = own_m_reg;  end
        3'd4: begin mul_a = prob_reg[4]; mul_b = own_i_reg;  end
        3'd5: begin mul_a = prob_reg[5]; mul_b = left_m_reg; end
        3'd6: begin mul_a = prob_reg[6]; mul_b = left_d_reg; end
        default: begin mul_a = '0; mul_b = '0; end
      endcase
    end
  end

  // State register; reset aborts whatever operation is in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = MAC;
      end
      MAC:   if (idx_reg == 3'd6) state_next = FINAL;
      FINAL: state_next = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, accumulation, result staging and history update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_reg <= '0;
      for (int i = 0; i < 7; i++) prob_reg[i] <= '0;
      prior_reg  <= '0; diag_m_reg <= '0; diag_i_reg <= '0; diag_d_reg <= '0;
      left_m_reg <= '0; left_d_reg <= '0; own_m_reg  <= '0; own_i_reg  <= '0;
      acc_m_reg  <= '0; acc_i_reg  <= '0; acc_d_reg  <= '0;
      result_m_reg <= '0; result_i_reg <= '0; result_d_reg <= '0;
      cur_m_reg  <= '0; cur_i_reg  <= '0; cur_d_reg  <= '0;
      prev_m_reg <= '0; prev_i_reg <= '0; prev_d_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (bus.in_valid) begin
          for (int i = 0; i < 7; i++) prob_reg[i] <= prob_in[i];
          prior_reg  <= bus.prior;
          diag_m_reg <= bus.diag_m;
          diag_i_reg <= bus.diag_i;
          diag_d_reg <= bus.diag_d;
          left_m_reg <= bus.left_m;
          left_d_reg <= bus.left_d;
          // Row start only hides history from this computation; cur_*/prev_* stay put.
          own_m_reg  <= bus.row_start ? '0 : cur_m_reg;
          own_i_reg  <= bus.row_start ? '0 : cur_i_reg;
          acc_m_reg  <= '0;
          acc_i_reg  <= '0;
          acc_d_reg  <= '0;
          idx_reg    <= '0;
        end
        MAC: begin
          idx_reg <= idx_reg + 3'd1;
          if (idx_reg <= 3'd2)      acc_m_reg <= fx_add(acc_m_reg, mul_res);
          else if (idx_reg <= 3'd4) acc_i_reg <= fx_add(acc_i_reg, mul_res);
          else                      acc_d_reg <= fx_add(acc_d_reg, mul_res);
        end
        FINAL: begin
          result_m_reg <= mul_res;
          result_i_reg <= acc_i_reg;
          result_d_reg <= acc_d_reg;
        end
        HOLD: if (bus.out_ready) begin
          prev_m_reg <= cur_m_reg;
          prev_i_reg <= cur_i_reg;
          prev_d_reg <= cur_d_reg;
          cur_m_reg  <= result_m_reg;
          cur_i_reg  <= result_i_reg;
          cur_d_reg  <= result_d_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.cur_m     = cur_m_reg;
  assign bus.cur_i     = cur_i_reg;
  assign bus.cur_d     = cur_d_reg;
  assign bus.prev_m    = prev_m_reg;
  assign bus.prev_i    = prev_i_reg;
  assign bus.prev_d    = prev_d_reg;

endmodule
